key_digit_buffer: RTL and testbench
===================================

KEY_DIGIT_BUFFER -- requirements
Module: key_digit_buffer

Interface
REQ-001 Parameter DIGITS, default 4: number of 4-bit BCD digits held in the entry buffer (range 1..8).
REQ-002 Parameter CLEAR_ON_ENTER, default 1: 1 = buffer empties when Enter is released; 0 = buffer retained.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
REQ-005 scan_valid  input  1  one-cycle strobe; scan_code holds a complete PS/2 byte.
REQ-006 scan_code  input  8  received PS/2 scan-code byte.
REQ-007 digits  output  4*DIGITS  live BCD entry; nibble 0 = most recently typed digit.
REQ-008 digit_count  output  4  number of valid digits in the buffer, 0..DIGITS.
REQ-009 value  output  4*DIGITS  snapshot of digits taken at the last Enter.
REQ-010 key_released  output  1  one-cycle pulse per completed break sequence (F0 xx or E0 F0 xx).
REQ-011 key_code  output  8  code of the last released key; key_ext  output  1  set if it was E0-prefixed.
REQ-012 enter  output  1  one-cycle pulse when Enter (0x5A, non-extended) is released.
REQ-013 overflow  output  1  sticky; set when a digit arrives with the buffer full.

Function
REQ-014 Decoder FSM states: IDLE, GOT_F0, GOT_E0, GOT_E0F0; it advances only on cycles with scan_valid=1.
REQ-015 IDLE: 0xF0 -> GOT_F0; 0xE0 -> GOT_E0; any other byte is a make or typematic-repeat code, ignored, stays IDLE.
REQ-016 GOT_E0: 0xF0 -> GOT_E0F0; any other byte -> IDLE with no action.
REQ-017 GOT_F0: byte b is the release code; pulse key_released, key_code<=b, key_ext<=0, apply REQ-019..REQ-023, -> IDLE.
REQ-018 GOT_E0F0: byte b; pulse key_released, key_code<=b, key_ext<=1, no buffer action, -> IDLE (extended keypad Enter and '/' are ignored).
REQ-019 Digit map (non-extended): main row 45,16,1E,26,25,2E,36,3D,3E,46 and keypad 70,69,72,7A,6B,73,74,6C,75,7D map to digits 0..9 respectively.
REQ-020 Digit with digit_count<DIGITS: digits<=(digits<<4)|d, digit_count+1.
REQ-021 Digit with digit_count==DIGITS: buffer and count unchanged, overflow<=1.
REQ-022 Backspace 0x66: if digit_count>0, digits<=digits>>4 (zero fill at top), digit_count-1; if 0, no change.
REQ-023 Escape 0x76: digits<=0, digit_count<=0, overflow<=0.
REQ-024 Enter 0x5A: value<=digits, enter pulse; if CLEAR_ON_ENTER=1, digits<=0, digit_count<=0 and overflow<=0 in the same edge.
REQ-025 All other release codes: key_released/key_code only, no buffer change.
REQ-026 Latency: every output updates on the edge that samples the final byte of a sequence and is visible the next cycle; key_released and enter are high for exactly one cycle.
REQ-027 scan_valid=0 cycles never change state; back-to-back scan_valid cycles are each processed.
REQ-028 An unrecognised byte never blocks the FSM; every state reaches IDLE within one byte.

Reset
REQ-029 On reset: FSM=IDLE; digits, value, key_code=0; digit_count=0; key_released, key_ext, enter, overflow=0.
REQ-030 Reset asserted mid-sequence (e.g. after F0) discards the partial sequence; the next byte is decoded from IDLE.

Verification
REQ-031 DIGITS=4: bytes 16,F0,16,1E,F0,1E -> digits=0x0012, digit_count=2, two key_released pulses, no action on make codes.
REQ-032 Release 1,2,3,4,5 -> digits=0x1234, digit_count=4, overflow=1; then F0 66 -> digits=0x0123, digit_count=3.
REQ-033 With 0x0123 in the buffer, F0 5A, CLEAR_ON_ENTER=1 -> value=0x0123, enter pulse 1 cycle, digits=0, digit_count=0, overflow=0.
REQ-034 E0 F0 5A -> key_released=1, key_ext=1, key_code=0x5A, no enter pulse, buffer unchanged.
REQ-035 F0 then reset pulse, then 16 -> no release; then F0 16 -> digits=0x0001.
REQ-036 F0 66 with digit_count=0 -> no change; F0 76 after overflow -> all buffer state 0.

Source files
------------

// File: rtl/key_digit_buffer.sv
// key_digit_buffer
//   Decodes PS/2 set-2 break sequences (F0 xx, E0 F0 xx) and keeps a
//   shift-in buffer of BCD digits typed on the main row or the keypad.
//   Backspace drops the newest digit, Escape clears everything, and Enter
//   snapshots the buffer into value. Enter optionally clears the buffer.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   scan_valid   one-cycle strobe qualifying scan_code
//   scan_code    received PS/2 byte
//   digits       live BCD entry, nibble 0 = most recently typed digit
//   digit_count  number of valid digits, 0..DIGITS
//   value        snapshot of digits taken at the last Enter
//   key_released one-cycle pulse per completed break sequence
//   key_code     code of the last released key
//   key_ext      last released key was E0-prefixed
//   enter        one-cycle pulse when non-extended Enter is released
//   overflow     sticky, set when a digit arrives with the buffer full
module key_digit_buffer #(
    parameter int unsigned DIGITS         = 4,
    parameter bit          CLEAR_ON_ENTER = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_valid,
    input  logic [7:0]          scan_code,
    output logic [4*DIGITS-1:0] digits,
    output logic [3:0]          digit_count,
    output logic [4*DIGITS-1:0] value,
    output logic                key_released,
    output logic [7:0]          key_code,
    output logic                key_ext,
    output logic                enter,
    output logic                overflow
);

    typedef enum logic [1:0] {
        IDLE,
        GOT_F0,
        GOT_E0,
        GOT_E0F0
    } state_t;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [3:0] FULL     = 4'(DIGITS);

    state_t state;

    logic                is_digit;
    logic [3:0]          digit_val;
    logic [4*DIGITS-1:0] digit_ext;

    // Scan code to BCD digit, main row and keypad share the same values.
    always_comb begin
        is_digit  = 1'b1;
        digit_val = 4'd0;
        case (scan_code)
            8'h45, 8'h70: digit_val = 4'd0;
            8'h16, 8'h69: digit_val = 4'd1;
            8'h1E, 8'h72: digit_val = 4'd2;
            8'h26, 8'h7A: digit_val = 4'd3;
            8'h25, 8'h6B: digit_val = 4'd4;
            8'h2E, 8'h73: digit_val = 4'd5;
            8'h36, 8'h74: digit_val = 4'd6;
            8'h3D, 8'h6C: digit_val = 4'd7;
            8'h3E, 8'h75: digit_val = 4'd8;
            8'h46, 8'h7D: digit_val = 4'd9;
            default:      is_digit  = 1'b0;
        endcase
        // Zero-extended digit; built by assignment so DIGITS=1 needs no
        // zero-width replication.
        digit_ext      = '0;
        digit_ext[3:0] = digit_val;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            digits       <= '0;
            digit_count  <= '0;
            value        <= '0;
            key_released <= 1'b0;
            key_code     <= '0;
            key_ext      <= 1'b0;
            enter        <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            key_released <= 1'b0;
            enter        <= 1'b0;
            if (scan_valid) begin
                unique case (state)
                    IDLE: begin
                        // Make and typematic codes are ignored here.
                        if (scan_code == SC_BREAK)
                            state <= GOT_F0;
                        else if (scan_code == SC_EXT)
                            state <= GOT_E0;
                    end
                    GOT_E0: begin
                        state <= (scan_code == SC_BREAK) ? GOT_E0F0 : IDLE;
                    end
                    GOT_E0F0: begin
                        // Extended keys (keypad Enter, '/') never touch the buffer.
                        key_released <= 1'b1;
                        key_code     <= scan_code;
                        key_ext      <= 1'b1;
                        state        <= IDLE;
                    end
                    GOT_F0: begin
                        key_released <= 1'b1;
                        key_code     <= scan_code;
                        key_ext      <= 1'b0;
                        state        <= IDLE;
                        if (is_digit) begin
                            if (digit_count < FULL) begin
                                digits      <= (digits << 4) | digit_ext;
                                digit_count <= digit_count + 4'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            case (scan_code)
                                SC_BKSP: begin
                                    if (digit_count != 4'd0) begin
                                        digits      <= digits >> 4;
                                        digit_count <= digit_count - 4'd1;
                                    end
                                end
                                SC_ESC: begin
                                    digits      <= '0;
                                    digit_count <= '0;
                                    overflow    <= 1'b0;
                                end
                                SC_ENTER: begin
                                    value <= digits;
                                    enter <= 1'b1;
                                    if (CLEAR_ON_ENTER) begin
                                        digits      <= '0;
                                        digit_count <= '0;
                                        overflow    <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_digit_buffer.sv
// Testbench for key_digit_buffer (DIGITS=4, CLEAR_ON_ENTER=1).
// Directed scenarios plus a randomized byte stream, all checked every cycle
// against a queue-based model of the typed digits.
module tb_key_digit_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scan_valid = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic [15:0] digits;
    logic [3:0]  digit_count;
    logic [15:0] value;
    logic        key_released;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        enter;
    logic        overflow;

    key_digit_buffer #(
        .DIGITS(4),
        .CLEAR_ON_ENTER(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_valid(scan_valid),
        .scan_code(scan_code),
        .digits(digits),
        .digit_count(digit_count),
        .value(value),
        .key_released(key_released),
        .key_code(key_code),
        .key_ext(key_ext),
        .enter(enter),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] main_row [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] keypad   [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    int          typed[$];     // typed[0] = newest digit
    bit          m_ovf;
    logic [15:0] m_value;
    logic [7:0]  m_code;
    bit          m_ext;
    bit          pend_f0, pend_e0;
    bit          exp_rel, exp_enter;

    function automatic int digit_of(input logic [7:0] b);
        for (int i = 0; i < 10; i++)
            if (main_row[i] == b || keypad[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [15:0] typed_value();
        int acc = 0;
        int w = 1;
        foreach (typed[i]) begin
            acc += typed[i] * w;
            w *= 16;
        end
        return 16'(acc);
    endfunction

    task automatic model_reset();
        typed.delete();
        m_ovf = 0; m_value = '0; m_code = '0; m_ext = 0;
        pend_f0 = 0; pend_e0 = 0; exp_rel = 0; exp_enter = 0;
    endtask

    task automatic model_release(input logic [7:0] b, input bit ext);
        int d;
        exp_rel = 1;
        m_code  = b;
        m_ext   = ext;
        if (ext) return;
        d = digit_of(b);
        if (d >= 0) begin
            if (typed.size() < 4) typed.push_front(d);
            else m_ovf = 1;
        end else if (b == 8'h66) begin
            if (typed.size() > 0) void'(typed.pop_front());
        end else if (b == 8'h76) begin
            typed.delete(); m_ovf = 0;
        end else if (b == 8'h5A) begin
            m_value = typed_value();
            exp_enter = 1;
            typed.delete(); m_ovf = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_rel = 0; exp_enter = 0;
        if (pend_f0) begin
            model_release(b, pend_e0);
            pend_f0 = 0; pend_e0 = 0;
        end else if (pend_e0) begin
            if (b == 8'hF0) pend_f0 = 1;
            else pend_e0 = 0;
        end else if (b == 8'hF0) pend_f0 = 1;
        else if (b == 8'hE0) pend_e0 = 1;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".digits"}, 32'(digits), 32'(typed_value()));
        check_eq({tag, ".count"}, 32'(digit_count), 32'(typed.size()));
        check_eq({tag, ".value"}, 32'(value), 32'(m_value));
        check_eq({tag, ".rel"}, 32'(key_released), 32'(exp_rel));
        check_eq({tag, ".code"}, 32'(key_code), 32'(m_code));
        check_eq({tag, ".ext"}, 32'(key_ext), 32'(m_ext));
        check_eq({tag, ".enter"}, 32'(enter), 32'(exp_enter));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit v, input logic [7:0] b);
        @(negedge clk);
        scan_valid = v;
        scan_code  = b;
        @(posedge clk);
        if (v) model_byte(b);
        else begin exp_rel = 0; exp_enter = 0; end
        #1;
        compare_all("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        scan_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("reset");
        #1;
        reset = 1'b0;
    endtask

    task automatic release_key(input logic [7:0] b);
        step(1'b1, 8'hF0);
        step(1'b1, b);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            0, 1:    return 8'hF0;
            2:       return 8'hE0;
            3, 4:    return ($urandom_range(0, 1) != 0) ? main_row[$urandom_range(0, 9)]
                                                         : keypad[$urandom_range(0, 9)];
            5:       return 8'h66;
            6:       return 8'h76;
            7:       return 8'h5A;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    int nrel;

    initial begin
        model_reset();
        do_reset();

        // Make codes ignored, two releases build 0x0012.
        nrel = 0;
        step(1'b1, 8'h16); nrel += int'(key_released);
        step(1'b1, 8'hF0); nrel += int'(key_released);
        step(1'b1, 8'h16); nrel += int'(key_released);
        step(1'b1, 8'h1E); nrel += int'(key_released);
        step(1'b1, 8'hF0); nrel += int'(key_released);
        step(1'b1, 8'h1E); nrel += int'(key_released);
        step(1'b0, 8'h00); nrel += int'(key_released);
        check_eq("seq1.digits", 32'(digits), 32'h0012);
        check_eq("seq1.count", 32'(digit_count), 2);
        check_eq("seq1.nrel", 32'(nrel), 2);

        // Fill past capacity, then backspace.
        release_key(8'h76);
        release_key(8'h16); release_key(8'h1E); release_key(8'h26);
        release_key(8'h25); release_key(8'h2E);
        check_eq("fill.digits", 32'(digits), 32'h1234);
        check_eq("fill.count", 32'(digit_count), 4);
        check_eq("fill.ovf", 32'(overflow), 1);
        release_key(8'h66);
        check_eq("bksp.digits", 32'(digits), 32'h0123);
        check_eq("bksp.count", 32'(digit_count), 3);

        // Enter snapshots and clears; pulse lasts one cycle.
        release_key(8'h5A);
        check_eq("enter.value", 32'(value), 32'h0123);
        check_eq("enter.pulse", 32'(enter), 1);
        check_eq("enter.digits", 32'(digits), 0);
        check_eq("enter.count", 32'(digit_count), 0);
        check_eq("enter.ovf", 32'(overflow), 0);
        step(1'b0, 8'h00);
        check_eq("enter.pulse_end", 32'(enter), 0);

        // Extended Enter: release only.
        release_key(8'h16);
        step(1'b1, 8'hE0); step(1'b1, 8'hF0); step(1'b1, 8'h5A);
        check_eq("ext.rel", 32'(key_released), 1);
        check_eq("ext.ext", 32'(key_ext), 1);
        check_eq("ext.code", 32'(key_code), 32'h5A);
        check_eq("ext.enter", 32'(enter), 0);
        check_eq("ext.digits", 32'(digits), 32'h0001);

        // Reset mid-sequence discards the pending F0.
        do_reset();
        step(1'b1, 8'hF0);
        do_reset();
        step(1'b1, 8'h16);
        check_eq("rstmid.rel", 32'(key_released), 0);
        release_key(8'h16);
        check_eq("rstmid.digits", 32'(digits), 32'h0001);

        // Backspace on empty buffer, Escape after overflow.
        release_key(8'h76);
        release_key(8'h66);
        check_eq("bkempty.digits", 32'(digits), 0);
        check_eq("bkempty.count", 32'(digit_count), 0);
        for (int i = 0; i < 5; i++) release_key(keypad[i]);
        check_eq("ovf2.ovf", 32'(overflow), 1);
        release_key(8'h76);
        check_eq("esc.digits", 32'(digits), 0);
        check_eq("esc.count", 32'(digit_count), 0);
        check_eq("esc.ovf", 32'(overflow), 0);

        // Randomized stream with idle gaps, back-to-back bytes and resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom_range(0, 255)));
            else step(1'b1, rand_byte());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
